// File: rtl/seq_arith_unit.sv
// seq_arith_unit: handshaked ADD/SUB plus an iterative shift-add multiplier.
// Optional MAC operation (op 11) with a wrapping accumulator is enabled by
// defining the macro SEQ_ARITH_MAC_EN; without it op 11 is reported illegal.
module seq_arith_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [1:0]         i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_result,
  output logic               o_flag,
  output logic               o_busy
);

  localparam int unsigned RES_W = 2 * WIDTH;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q,  state_d;
  logic               ready_q,  ready_d;
  logic               valid_q,  valid_d;
  logic               busy_q,   busy_d;
  logic               flag_q,   flag_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [RES_W-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [RES_W-1:0]   prod_q,   prod_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [RES_W-1:0]   prod_step;

`ifdef SEQ_ARITH_MAC_EN
  logic [RES_W:0]     acc_q, acc_d;
  logic               mac_q, mac_d;
  logic [RES_W:0]     acc_sum;
`endif

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    flag_d   = flag_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
`ifdef SEQ_ARITH_MAC_EN
    acc_d    = acc_q;
    mac_d    = mac_q;
`endif

    sum       = {1'b0, i_a} + {1'b0, i_b};
    diff      = {1'b0, i_a} - {1'b0, i_b};
    // Partial product including this cycle's conditional add
    prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
`ifdef SEQ_ARITH_MAC_EN
    acc_sum   = acc_q + {1'b0, prod_step};
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_valid && ready_q) begin
          ready_d = 1'b0;
          busy_d  = 1'b1;
          unique case (i_op)
            OP_ADD: begin
              result_d = RES_W'(sum);
              flag_d   = sum[WIDTH];
              valid_d  = 1'b1;
              state_d  = S_DONE;
            end
            OP_SUB: begin
              result_d = RES_W'(diff[WIDTH-1:0]);
              flag_d   = diff[WIDTH];
              valid_d  = 1'b1;
              state_d  = S_DONE;
            end
            OP_MUL: begin
              mcand_d  = RES_W'(i_a);
              mplier_d = i_b;
              cnt_d    = CNT_W'(WIDTH);
              prod_d   = '0;
              state_d  = S_MUL;
`ifdef SEQ_ARITH_MAC_EN
              mac_d    = 1'b0;
`endif
            end
            default: begin
`ifdef SEQ_ARITH_MAC_EN
              mcand_d  = RES_W'(i_a);
              mplier_d = i_b;
              cnt_d    = CNT_W'(WIDTH);
              prod_d   = '0;
              mac_d    = 1'b1;
              state_d  = S_MUL;
`else
              result_d = '0;
              flag_d   = 1'b1;
              valid_d  = 1'b1;
              state_d  = S_DONE;
`endif
            end
          endcase
        end
      end

      S_MUL: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        // Last iteration: publish the finished product this edge
        if (cnt_q == CNT_W'(1)) begin
          result_d = prod_step;
          flag_d   = 1'b0;
          valid_d  = 1'b1;
          state_d  = S_DONE;
`ifdef SEQ_ARITH_MAC_EN
          if (mac_q) begin
            result_d = acc_sum[RES_W-1:0];
            flag_d   = acc_sum[RES_W];
            acc_d    = {1'b0, acc_sum[RES_W-1:0]};
          end
`endif
        end
      end

      S_DONE: begin
        if (valid_q && i_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      flag_q   <= 1'b0;
      result_q <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
`ifdef SEQ_ARITH_MAC_EN
      acc_q    <= '0;
      mac_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      flag_q   <= flag_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
`ifdef SEQ_ARITH_MAC_EN
      acc_q    <= acc_d;
      mac_q    <= mac_d;
`endif
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_busy   = busy_q;
  assign o_flag   = flag_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Self-checking bench for seq_arith_unit (WIDTH=8); scoreboard of expected results.
module tb_seq_arith_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned RES_W = 2 * WIDTH;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [1:0]       i_op = 2'b00;
  logic [WIDTH-1:0] i_a = '0;
  logic [WIDTH-1:0] i_b = '0;
  logic             o_valid;
  logic             i_ready = 1'b1;
  logic [RES_W-1:0] o_result;
  logic             o_flag;
  logic             o_busy;

  typedef struct {
    logic [RES_W-1:0] res;
    logic             flag;
    int               lat;
  } exp_t;

  exp_t           sb[$];
  int             n_cmp = 0;
  int             n_err = 0;
  logic [RES_W:0] acc_m = '0;

  seq_arith_unit #(.WIDTH(WIDTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_flag(o_flag), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model of one operation
  function automatic exp_t model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    exp_t             e;
    logic [WIDTH:0]   t;
    logic [RES_W:0]   s;
    logic [RES_W-1:0] p;
    t = '0; s = '0; p = '0;
    case (op)
      2'b00: begin t = {1'b0, a} + {1'b0, b}; e.res = RES_W'(t); e.flag = t[WIDTH]; e.lat = 1; end
      2'b01: begin e.res = RES_W'(WIDTH'(a - b)); e.flag = (a < b); e.lat = 1; end
      2'b10: begin e.res = RES_W'(a) * RES_W'(b); e.flag = 1'b0; e.lat = WIDTH + 1; end
      default: begin
`ifdef SEQ_ARITH_MAC_EN
        p = RES_W'(a) * RES_W'(b);
        s = acc_m + {1'b0, p};
        e.res = s[RES_W-1:0]; e.flag = s[RES_W]; e.lat = WIDTH + 1;
        acc_m = {1'b0, s[RES_W-1:0]};
`else
        e.res = '0; e.flag = 1'b1; e.lat = 1;
`endif
      end
    endcase
    return e;
  endfunction

  // Drive one command; called #1 after a posedge while the DUT is idle
  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
    sb.push_back(model(op, a, b));
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_a = WIDTH'($urandom); i_b = WIDTH'($urandom); i_op = 2'($urandom);
  endtask

  // Cycles from accept edge until o_valid is seen; -1 on timeout. Returns at a negedge.
  task automatic wait_out(output int lat);
    lat = 1;
    forever begin
      @(negedge i_clk);
      if (o_valid === 1'b1) break;
      if (lat >= 40) begin lat = -1; break; end
      @(posedge i_clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1; acc_m = '0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (o_ready !== 1'b1)  begin n_err++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    n_cmp++; if (o_valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_result !== '0)   begin n_err++; $display("FAIL reset_result: got %h want 0", o_result); end
    n_cmp++; if (o_flag !== 1'b0)   begin n_err++; $display("FAIL reset_flag: got %b want 0", o_flag); end
    n_cmp++; if (o_busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    @(posedge i_clk); #1;
  endtask

  task automatic test_add_sub;
    logic [1:0]       ops[3] = '{2'b00, 2'b00, 2'b01};
    logic [WIDTH-1:0] as[3]  = '{8'h30, 8'hFC, 8'h04};
    logic [WIDTH-1:0] bs[3]  = '{8'h14, 8'h04, 8'hFC};
    logic [RES_W-1:0] want[3] = '{16'h0044, 16'h0100, 16'h0008};
    logic             wflag[3] = '{1'b0, 1'b1, 1'b1};
    exp_t e; int lat;
    for (int i = 0; i < 3; i++) begin
      send(ops[i], as[i], bs[i]);
      wait_out(lat);
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL addsub%0d_lat: got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (o_result !== want[i] || e.res !== want[i]) begin n_err++; $display("FAIL addsub%0d_result: got %h want %h", i, o_result, want[i]); end
      n_cmp++; if (o_flag !== wflag[i]) begin n_err++; $display("FAIL addsub%0d_flag: got %b want %b", i, o_flag, wflag[i]); end
      n_cmp++; if (o_ready !== 1'b0 || o_busy !== 1'b1) begin n_err++; $display("FAIL addsub%0d_done_hs: got ready=%b busy=%b want 0/1", i, o_ready, o_busy); end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_mul;
    logic [WIDTH-1:0] as[3] = '{8'h30, 8'hFF, 8'h00};
    logic [WIDTH-1:0] bs[3] = '{8'h14, 8'hFF, 8'h55};
    exp_t e; int lat;
    for (int i = 0; i < 3; i++) begin
      send(2'b10, as[i], bs[i]);
      n_cmp++; if (o_busy !== 1'b1 || o_ready !== 1'b0) begin n_err++; $display("FAIL mul%0d_busy: got busy=%b ready=%b want 1/0", i, o_busy, o_ready); end
      wait_out(lat);
      e = sb.pop_front();
      n_cmp++; if (lat !== WIDTH + 1) begin n_err++; $display("FAIL mul%0d_lat: got %0d want %0d", i, lat, WIDTH + 1); end
      n_cmp++; if (o_result !== e.res) begin n_err++; $display("FAIL mul%0d_result: got %h want %h", i, o_result, e.res); end
      n_cmp++; if (o_flag !== 1'b0) begin n_err++; $display("FAIL mul%0d_flag: got %b want 0", i, o_flag); end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    exp_t e; int lat; logic [1:0] op;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 2));
      send(op, WIDTH'($urandom), WIDTH'($urandom));
      wait_out(lat);
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat || o_result !== e.res || o_flag !== e.flag) begin
        n_err++; $display("FAIL b2b%0d op%0d: got lat=%0d res=%h flag=%b want lat=%0d res=%h flag=%b",
                          i, op, lat, o_result, o_flag, e.lat, e.res, e.flag);
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_backpressure;
    exp_t e; int lat;
    i_ready = 1'b0;
    send(2'b10, 8'h12, 8'h34);
    wait_out(lat);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat || o_result !== e.res) begin n_err++; $display("FAIL bp_first: got lat=%0d res=%h want lat=%0d res=%h", lat, o_result, e.lat, e.res); end
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk); #1;
      i_valid = 1'b1; i_op = 2'($urandom_range(0, 2)); i_a = WIDTH'($urandom); i_b = WIDTH'($urandom);
      @(negedge i_clk);
      n_cmp++; if (o_result !== e.res || o_valid !== 1'b1 || o_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold%0d: got res=%h valid=%b ready=%b want res=%h valid=1 ready=0", i, o_result, o_valid, o_ready, e.res);
      end
    end
    @(posedge i_clk); #1 i_ready = 1'b1;
    @(posedge i_clk); #1 i_valid = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL bp_release: got valid=%b ready=%b busy=%b want 0/1/0", o_valid, o_ready, o_busy);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset_mid_mul;
    exp_t e; int lat;
    send(2'b10, 8'h30, 8'h14);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid%0d: got %b want 0", i, o_valid); end
      @(posedge i_clk);
      if (i == 2) #1 i_reset = 1'b1;
    end
    #1 i_reset = 1'b0;
    void'(sb.pop_back());
    acc_m = '0;
    @(negedge i_clk);
    n_cmp++; if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== '0 || o_flag !== 1'b0 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_values: got ready=%b valid=%b res=%h flag=%b busy=%b want 1/0/0000/0/0",
                        o_ready, o_valid, o_result, o_flag, o_busy);
    end
    @(posedge i_clk); #1;
    send(2'b00, 8'h01, 8'h01);
    wait_out(lat);
    e = sb.pop_front();
    n_cmp++; if (lat !== 1 || o_result !== 16'h0002 || e.res !== 16'h0002) begin n_err++; $display("FAIL rst_mid_add: got lat=%0d res=%h want 1/0002", lat, o_result); end
    @(posedge i_clk); #1;
  endtask

  task automatic test_op11;
    exp_t e; int lat;
`ifdef SEQ_ARITH_MAC_EN
    logic [RES_W-1:0] want[2] = '{16'h0100, 16'h0200};
    logic             wflag[2] = '{1'b0, 1'b0};
`else
    logic [RES_W-1:0] want[2] = '{16'h0000, 16'h0000};
    logic             wflag[2] = '{1'b1, 1'b1};
`endif
    for (int i = 0; i < 2; i++) begin
      send(2'b11, 8'h80, 8'h02);
      wait_out(lat);
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL op11_%0d_lat: got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (o_result !== want[i]) begin n_err++; $display("FAIL op11_%0d_result: got %h want %h", i, o_result, want[i]); end
      n_cmp++; if (o_flag !== wflag[i]) begin n_err++; $display("FAIL op11_%0d_flag: got %b want %b", i, o_flag, wflag[i]); end
      @(posedge i_clk); #1;
    end
`ifdef SEQ_ARITH_MAC_EN
    for (int i = 0; i < 4; i++) begin
      send(2'b11, 8'hFF, 8'hFF);
      wait_out(lat);
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat || o_result !== e.res || o_flag !== e.flag) begin
        n_err++; $display("FAIL mac_wrap%0d: got lat=%0d res=%h flag=%b want lat=%0d res=%h flag=%b",
                          i, lat, o_result, o_flag, e.lat, e.res, e.flag);
      end
      @(posedge i_clk); #1;
      if (e.flag) break;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mul();
    test_op11();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
- Parametrised successor to the team's combinational adder/multiplier pair.
- One block with valid/ready handshakes, op select and an iterative shift-add multiplier, so the datapath no longer needs a full array multiplier.
- Sits between an operand source (stimulus or pipeline stage) and a result consumer.
- Accepts one operation at a time and holds the result until the consumer takes it.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter.

Ports:
- i_clk, input, 1: clock; all logic rises on posedge.
- i_reset, input, 1: synchronous, active-high reset.
- i_valid, input, 1: operand/op presented.
- o_ready, output, 1: block can accept a command.
- i_op, input, 2: 00 ADD, 01 SUB, 10 MUL, 11 MAC/illegal (see Optional Feature).
- i_a, input, WIDTH: operand A, unsigned.
- i_b, input, WIDTH: operand B, unsigned.
- o_valid, output, 1: result available.
- i_ready, input, 1: consumer accepts result.
- o_result, output, 2*WIDTH: result, zero-extended.
- o_flag, output, 1: ADD carry / SUB borrow / MAC overflow / illegal-op.
- o_busy, output, 1: high in any state other than IDLE.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. Clock port is i_clk, reset port is i_reset.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_result=0, o_flag=0, o_busy=0, counter=0, accumulator=0.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - o_ready=1.
  - Handshake fires on posedge with i_valid&&o_ready. Operands and op are captured on that edge.
  - ADD/SUB/illegal: result computed and registered on the accept edge; next state DONE.
  - MUL/MAC: load multiplicand, multiplier and counter=WIDTH, clear partial product; next state MUL.
- ADD: o_result = {0, a+b} using WIDTH+1 bits; o_flag = bit WIDTH of the sum (carry).
- SUB: o_result = {0, (a-b) mod 2^WIDTH}; o_flag = 1 if a<b (borrow).
- MUL state:
  - Each cycle: if multiplier LSB=1, add multiplicand<<i into the 2*WIDTH partial product; shift the multiplier right; decrement the counter.
  - When the counter reaches 0, register the product to o_result, set o_flag=0, go to DONE.
  - Exactly WIDTH cycles are spent in MUL.
- DONE:
  - o_valid=1, o_ready=0; o_result and o_flag held stable.
  - On i_valid&&... rather, on o_valid&&i_ready, clear o_valid and return to IDLE. No new command is accepted on that same edge.
- Latency, counted from the accept edge to the edge where o_valid is first seen high:
  - ADD/SUB: 1 cycle.
  - MUL: WIDTH+1 cycles.
- Back-pressure: with i_ready low, DONE holds indefinitely with stable outputs.
- Inputs: i_a/i_b/i_op are ignored while o_ready=0. Changing them mid-MUL does not affect the result.
- Reset mid-operation: abort; all reset values apply on the next edge. No partial result is emitted.
- Zero operands: MUL still takes WIDTH cycles (fixed latency, no early exit).
- Throughput: at most one op per 2 cycles (ADD/SUB) or per WIDTH+2 cycles (MUL).

Optional Feature:
- Macro: SEQ_ARITH_MAC_EN.
- Defined:
  - op 11 = MAC. Runs the MUL sequence, then acc <= acc + product, using an internal 2*WIDTH+1-bit accumulator.
  - o_result = acc[2*WIDTH-1:0] after the add. o_flag = 1 if bit 2*WIDTH is set; that bit is then cleared, so the accumulator wraps.
  - Latency WIDTH+1, same as MUL.
  - The accumulator is cleared only by i_reset.
  - ADD/SUB/MUL do not touch the accumulator.
- Undefined:
  - op 11 is illegal. Behaves like ADD timing (1 cycle) with o_result=0, o_flag=1.
  - No accumulator register is synthesised.

Test Plan:
- WIDTH=8, i_ready=1. Reset 2 cycles, then ADD a=0x30 b=0x14 -> o_valid 1 cycle after accept, o_result=0x0044, o_flag=0.
- ADD a=0xFC b=0x04 -> o_result=0x0100, o_flag=1. SUB a=0x04 b=0xFC -> o_result=0x0008, o_flag=1.
- MUL a=0x30 b=0x14 -> o_busy high, o_valid exactly 9 cycles after accept, o_result=0x03C0. MUL a=0xFF b=0xFF -> 0xFE01. MUL a=0 b=0x55 -> 0x0000, still 9 cycles.
- Back-pressure: i_ready=0 for 5 cycles after o_valid.
  - o_result stays stable and o_ready stays 0.
  - Operands driven meanwhile are not accepted.
  - After i_ready=1: o_valid drops next edge and o_ready=1.
- Reset mid-MUL: assert i_reset 4 cycles after accepting MUL 0x30*0x14 -> o_valid never rises; next edge shows all reset values. A following ADD 1+1 returns 0x0002.
- Op 11, a=0x80 b=0x02, issued twice:
  - With SEQ_ARITH_MAC_EN: results 0x0100 then 0x0200, o_flag=0.
  - Then MAC 0xFF*0xFF repeated until acc exceeds 0xFFFF -> o_flag=1 on the wrap, with o_result equal to the wrapped sum.
  - Without SEQ_ARITH_MAC_EN: o_result=0, o_flag=1, latency 1.
